// File: rtl/mem_pkg.sv
// Shared types and sizes for the memory-stage load/store responder.
//   mem_op_t      request opcode (scalar/vector read/write)
//   resp_state_t  responder FSM state
//   SWORD_W       width of one storage word
//   VLANE_W       width of one vector lane
//   VLANES        number of lanes in a vector access
package mem_pkg;

    localparam int unsigned SWORD_W = 36;
    localparam int unsigned VLANE_W = 32;
    localparam int unsigned VLANES  = 4;

    typedef enum logic [1:0] {
        SREAD  = 2'd0,
        SWRITE = 2'd1,
        VREAD  = 2'd2,
        VWRITE = 2'd3
    } mem_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } resp_state_t;

endpackage

// File: rtl/mem_array.sv
// On-chip word storage: 2^DEPTH_LOG2 words of SWORD_W bits with a single
// VLANES-word-wide port starting at i_idx. Word i of the port maps to
// storage word i_idx+i (wrapping). Reads are combinational, writes happen on
// the rising edge for each word whose enable is set. Contents are not reset.
//   i_clk    clock
//   i_idx    base word index of the port
//   i_we     per-word write enables
//   i_wdata  write data, word i at [SWORD_W*i +: SWORD_W]
//   o_rdata  read data, same packing as i_wdata
module mem_array
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                        i_clk,
    input  logic [DEPTH_LOG2-1:0]       i_idx,
    input  logic [VLANES-1:0]           i_we,
    input  logic [VLANES*SWORD_W-1:0]   i_wdata,
    output logic [VLANES*SWORD_W-1:0]   o_rdata
);

    logic [SWORD_W-1:0] r_mem [2**DEPTH_LOG2];

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < VLANES; i++) begin
            if (i_we[i]) begin
                r_mem[i_idx + DEPTH_LOG2'(i)] <= i_wdata[i*SWORD_W +: SWORD_W];
            end
        end
    end

    always_comb begin
        o_rdata = '0;
        for (int i = 0; i < VLANES; i++) begin
            o_rdata[i*SWORD_W +: SWORD_W] = r_mem[i_idx + DEPTH_LOG2'(i)];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Responder for the memory-stage load/store interface. Accepts one scalar or
// vector request at a time, services it from mem_array after LATENCY cycles
// and returns a one-cycle response. Out-of-range or misaligned vector
// accesses write nothing, return zero data and set a sticky error.
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake
//   req_op/addr/wdata/vwdata/mask  request fields (latched on accept)
//   rsp_valid                  one-cycle response strobe
//   rsp_rdata/rsp_vrdata       registered scalar/vector read data
//   stall                      request in flight (pipeline cache stall)
//   err                        sticky error flag
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY    = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [1:0]   req_op,
    input  logic [35:0]  req_addr,
    input  logic [35:0]  req_wdata,
    input  logic [127:0] req_vwdata,
    input  logic [3:0]   req_mask,
    output logic         rsp_valid,
    output logic [35:0]  rsp_rdata,
    output logic [127:0] rsp_vrdata,
    output logic         stall,
    output logic         err
);

    resp_state_t r_state, w_state_d;
    logic [3:0]  r_cnt, w_cnt_d;

    mem_op_t      r_op;
    logic [35:0]  r_addr, r_wdata;
    logic [127:0] r_vwdata;
    logic [3:0]   r_mask;

    logic [35:0]  r_rsp_rdata;
    logic [127:0] r_rsp_vrdata;
    logic         r_err;

    logic w_accept, w_commit, w_bad;

    // Fields of the request being serviced. With LATENCY==1 the commit edge is
    // the accept edge, so the live inputs must be used while still in IDLE.
    mem_op_t      w_op;
    logic [35:0]  w_addr, w_wdata;
    logic [127:0] w_vwdata;
    logic [3:0]   w_mask;

    logic [VLANES-1:0]         w_we;
    logic [VLANES*SWORD_W-1:0] w_arr_wdata, w_arr_rdata;
    logic [35:0]               w_rdata_d;
    logic [127:0]              w_vrdata_d;
    logic                      w_unused_rdata;

    assign w_accept = req_valid & (r_state == IDLE);
    assign w_commit = ((r_state == WAIT) && (r_cnt == 4'd1)) || (w_accept && (LATENCY == 1));

    assign w_op     = (r_state == IDLE) ? mem_op_t'(req_op) : r_op;
    assign w_addr   = (r_state == IDLE) ? req_addr         : r_addr;
    assign w_wdata  = (r_state == IDLE) ? req_wdata        : r_wdata;
    assign w_vwdata = (r_state == IDLE) ? req_vwdata       : r_vwdata;
    assign w_mask   = (r_state == IDLE) ? req_mask         : r_mask;

    // Vector ops have op[1] set; they must be 4-word aligned.
    assign w_bad = (|w_addr[35:DEPTH_LOG2]) | (w_op[1] & (|w_addr[1:0]));

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_cnt_d   = 4'(LATENCY - 1);
                    w_state_d = (LATENCY > 1) ? WAIT : RESP;
                end
            end
            WAIT: begin
                w_cnt_d = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_d = RESP;
                end
            end
            RESP:    w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    always_comb begin
        w_we        = '0;
        w_arr_wdata = '0;
        unique case (w_op)
            SWRITE: begin
                w_we                     = 4'b0001;
                w_arr_wdata[SWORD_W-1:0] = w_wdata;
            end
            VWRITE: begin
                w_we = w_mask;
                for (int i = 0; i < VLANES; i++) begin
                    w_arr_wdata[i*SWORD_W +: SWORD_W] =
                        {{(SWORD_W-VLANE_W){1'b0}}, w_vwdata[i*VLANE_W +: VLANE_W]};
                end
            end
            default: ;
        endcase
        if (!w_commit || w_bad) begin
            w_we = '0;
        end
    end

    always_comb begin
        w_rdata_d  = '0;
        w_vrdata_d = '0;
        if (!w_bad) begin
            unique case (w_op)
                SREAD: w_rdata_d = w_arr_rdata[SWORD_W-1:0];
                VREAD: begin
                    for (int i = 0; i < VLANES; i++) begin
                        w_vrdata_d[i*VLANE_W +: VLANE_W] = w_arr_rdata[i*SWORD_W +: VLANE_W];
                    end
                end
                default: ;
            endcase
        end
    end

    // Upper bits of lanes 1..3 are never returned.
    assign w_unused_rdata = ^w_arr_rdata;

    mem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem_array (
        .i_clk   (clk),
        .i_idx   (w_addr[DEPTH_LOG2-1:0]),
        .i_we    (w_we),
        .i_wdata (w_arr_wdata),
        .o_rdata (w_arr_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_op         <= SREAD;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_vwdata     <= '0;
            r_mask       <= '0;
            r_rsp_rdata  <= '0;
            r_rsp_vrdata <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            if (w_accept) begin
                r_op     <= mem_op_t'(req_op);
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_vwdata <= req_vwdata;
                r_mask   <= req_mask;
            end
            if (w_commit) begin
                r_rsp_rdata  <= w_rdata_d;
                r_rsp_vrdata <= w_vrdata_d;
                if (w_bad) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign req_ready  = (r_state == IDLE);
    assign rsp_valid  = (r_state == RESP);
    assign rsp_rdata  = r_rsp_rdata;
    assign rsp_vrdata = r_rsp_vrdata;
    assign stall      = (r_state != IDLE) | w_accept;
    assign err        = r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: drivers push expected responses,
// monitors pop and compare whenever rsp_valid is seen on a falling edge.
module tb_data_mem_responder;
    import mem_pkg::*;

    localparam int LAT = 4;

    typedef struct {
        logic [35:0]  rd;
        logic [127:0] vrd;
        logic         er;
        int           due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_run  = 0;
    int n_fail = 0;

    exp_t q[$];
    int   q1[$];

    // Main instance, LATENCY=4
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0, req_ready;
    logic [1:0]   req_op = 2'd0;
    logic [35:0]  req_addr = '0, req_wdata = '0;
    logic [127:0] req_vwdata = '0;
    logic [3:0]   req_mask = '0;
    logic         rsp_valid, stall, err;
    logic [35:0]  rsp_rdata;
    logic [127:0] rsp_vrdata;

    // Second instance, LATENCY=1, used for back-to-back spacing
    logic         rst_n1 = 1'b0;
    logic         req_valid1 = 1'b0, req_ready1;
    logic [1:0]   req_op1 = 2'd0;
    logic [35:0]  req_addr1 = '0, req_wdata1 = '0;
    logic [127:0] req_vwdata1 = '0;
    logic [3:0]   req_mask1 = '0;
    logic         rsp_valid1, stall1, err1;
    logic [35:0]  rsp_rdata1;
    logic [127:0] rsp_vrdata1;

    data_mem_responder #(.DEPTH_LOG2(10), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_vwdata(req_vwdata), .req_mask(req_mask), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_vrdata(rsp_vrdata), .stall(stall), .err(err)
    );

    data_mem_responder #(.DEPTH_LOG2(10), .LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n1), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_op(req_op1), .req_addr(req_addr1), .req_wdata(req_wdata1),
        .req_vwdata(req_vwdata1), .req_mask(req_mask1), .rsp_valid(rsp_valid1),
        .rsp_rdata(rsp_rdata1), .rsp_vrdata(rsp_vrdata1), .stall(stall1), .err(err1)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor for the main instance
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (q.size() == 0) begin
                check("unexpected_rsp", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("rsp_rdata", rsp_rdata, e.rd);
                check("rsp_vrdata", rsp_vrdata, e.vrd);
                check("rsp_err", err, e.er);
                check("rsp_latency", cyc, e.due);
                check("rsp_stall", stall, 1);
            end
        end
    end

    // Monitor for the LATENCY=1 instance (only scalar writes are sent to it)
    always @(negedge clk) begin
        if (rsp_valid1) begin
            if (q1.size() == 0) begin
                check("unexpected_rsp1", 1, 0);
            end else begin
                int due;
                due = q1.pop_front();
                check("rsp1_rdata", rsp_rdata1, 0);
                check("rsp1_vrdata", rsp_vrdata1, 0);
                check("rsp1_latency", cyc, due);
            end
        end
    end

    task automatic issue(input mem_op_t op, input logic [35:0] addr, input logic [35:0] wd,
                         input logic [127:0] vwd, input logic [3:0] mask,
                         input logic [35:0] erd, input logic [127:0] evrd, input logic eerr);
        int guard = 0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_op     = op;
        req_addr   = addr;
        req_wdata  = wd;
        req_vwdata = vwd;
        req_mask   = mask;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            check("issue_timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
        q.push_back('{rd: erd, vrd: evrd, er: eerr, due: cyc + LAT});
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while ((q.size() != 0 || q1.size() != 0) && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        check("drain_empty", 128'(q.size() + q1.size()), 0);
        @(negedge clk);
    endtask

    // Hold req_valid for n cycles; accepts must be lat+1 apart.
    task automatic hold_test(input int sel, input int lat, input int n);
        int last = -1;
        int acc  = 0;
        logic rdy, stl;
        @(negedge clk);
        if (sel == 0) begin
            req_valid = 1'b1; req_op = SREAD; req_addr = 36'h10;
        end else begin
            req_valid1 = 1'b1; req_op1 = SWRITE; req_addr1 = 36'h5; req_wdata1 = 36'h77;
        end
        for (int k = 0; k < n; k++) begin
            rdy = (sel == 0) ? req_ready : req_ready1;
            stl = (sel == 0) ? stall : stall1;
            if (rdy) begin
                if (last >= 0) check("hold_spacing", 128'(cyc - last), 128'(lat + 1));
                last = cyc;
                acc++;
                if (sel == 0) q.push_back('{rd: 36'hABCDEF012, vrd: '0, er: 1'b0, due: cyc + lat});
                else q1.push_back(cyc + lat);
            end else begin
                check("hold_busy_stall", stl, 1);
            end
            @(negedge clk);
        end
        if (sel == 0) req_valid = 1'b0;
        else req_valid1 = 1'b0;
        check("hold_accepts", 128'(acc), 128'((n + lat) / (lat + 1)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        rst_n1 = 1'b1;
        @(negedge clk);
        check("reset_ready", req_ready, 1);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rdata", rsp_rdata, 0);
        check("reset_vrdata", rsp_vrdata, 0);
        check("reset_stall", stall, 0);
        check("reset_err", err, 0);

        // Combinational stall in the accept cycle
        req_valid = 1'b1;
        req_op    = SREAD;
        req_addr  = 36'h0;
        #1;
        check("accept_stall", stall, 1);
        req_valid = 1'b0;
        #1;
        check("idle_stall", stall, 0);

        issue(SWRITE, 36'h10, 36'hABCDEF012, '0, 4'h0, 36'h0, '0, 1'b0);
        issue(SREAD,  36'h10, '0, '0, 4'h0, 36'hABCDEF012, '0, 1'b0);
        issue(SWRITE, 36'h30, 36'h111, '0, 4'h0, 36'h0, '0, 1'b0);
        issue(VWRITE, 36'h20, '0, '0, 4'hF, 36'h0, '0, 1'b0);
        issue(SWRITE, 36'h21, 36'hFFFFFFFFF, '0, 4'h0, 36'h0, '0, 1'b0);
        issue(VWRITE, 36'h20, '0, {32'd4, 32'd3, 32'd2, 32'd1}, 4'b1010, 36'h0, '0, 1'b0);
        issue(VREAD,  36'h20, '0, '0, 4'h0, 36'h0, {32'd4, 32'd0, 32'd2, 32'd0}, 1'b0);
        issue(SREAD,  36'h21, '0, '0, 4'h0, 36'h000000002, '0, 1'b0);
        issue(SWRITE, 36'h22, 36'h512345678, '0, 4'h0, 36'h0, '0, 1'b0);
        issue(VREAD,  36'h20, '0, '0, 4'h0, 36'h0, {32'd4, 32'h12345678, 32'd2, 32'd0}, 1'b0);
        drain();

        hold_test(0, LAT, 25);
        hold_test(1, 1, 20);
        drain();

        // Error cases; err must stay set
        issue(VREAD,  36'h22, '0, '0, 4'h0, 36'h0, '0, 1'b1);
        issue(SREAD,  36'h400, '0, '0, 4'h0, 36'h0, '0, 1'b1);
        issue(SWRITE, 36'h410, 36'h999, '0, 4'h0, 36'h0, '0, 1'b1);
        issue(SREAD,  36'h10, '0, '0, 4'h0, 36'hABCDEF012, '0, 1'b1);
        issue(VWRITE, 36'h21, '0, {4{32'd7}}, 4'hF, 36'h0, '0, 1'b1);
        issue(SREAD,  36'h21, '0, '0, 4'h0, 36'h000000002, '0, 1'b1);
        issue(SREAD,  36'h22, '0, '0, 4'h0, 36'h512345678, '0, 1'b1);
        drain();
        check("err_sticky", err, 1);

        // Reset during WAIT of a write abandons it
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = SWRITE;
        req_addr  = 36'h30;
        req_wdata = 36'h222;
        @(negedge clk);
        req_valid = 1'b0;
        check("abandon_in_wait_ready", req_ready, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_ready", req_ready, 1);
        check("midreset_rsp_valid", rsp_valid, 0);
        check("midreset_rdata", rsp_rdata, 0);
        check("midreset_vrdata", rsp_vrdata, 0);
        check("midreset_stall", stall, 0);
        check("midreset_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(SREAD, 36'h30, '0, '0, 4'h0, 36'h111, '0, 1'b0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
